// File: rtl/cpu_pkg.sv
// Shared pipeline constants: register-file geometry and scoreboard counter width.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int SB_CNT_W   = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down in-flight counter for one tracked register.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Counter state: clear wins, simultaneous inc/dec holds, ends saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (inc && !dec && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (dec && !inc && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count   = cnt_r;
  assign nonzero = (cnt_r != CNT_ZERO);
  assign at_max  = (cnt_r == CNT_MAX);

endmodule

// File: rtl/wb_scoreboard.sv
// Register-writeback scoreboard: tracks pending destination writes from ID
// issue to WB retirement and raises the ID stall on RAW or counter saturation.
module wb_scoreboard #(
  parameter int NUM_REGS  = cpu_pkg::NUM_REGS,
  parameter int ADDR_W    = cpu_pkg::REG_ADDR_W,
  parameter int CNT_W     = cpu_pkg::SB_CNT_W,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Issue_valid,
  input  logic              Issue_wb_en,
  input  logic [ADDR_W-1:0] Issue_dst,
  input  logic [ADDR_W-1:0] Src1,
  input  logic [ADDR_W-1:0] Src2,
  input  logic              Src2_valid,
  input  logic              Wb_valid,
  input  logic [ADDR_W-1:0] Wb_dst,
  input  logic              Flush,
  output logic              Hazard_detected_signal,
  output logic              Busy,
  output logic              Wb_underflow
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] R0      = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] nz_s;
  logic [NUM_REGS-1:0] max_s;
  logic [NUM_REGS-1:1] issue_oh_s;
  logic [NUM_REGS-1:1] rel_oh_s;
  logic                issue_fire_s;
  logic                hazard_s;
  logic                underflow_evt_s;
  logic                underflow_r;

  // A source is pending unless a same-cycle final writeback releases it.
  function automatic logic pending(input logic [ADDR_W-1:0] s,
                                   input logic [CNT_W-1:0]  c,
                                   input logic              wbv,
                                   input logic [ADDR_W-1:0] wd);
    logic bypass;
    bypass  = (WB_BYPASS != 0) && wbv && (wd == s) && (c == CNT_ONE);
    pending = (s != R0) && (c != {CNT_W{1'b0}}) && !bypass;
  endfunction

  assign cnt_s[0] = {CNT_W{1'b0}};
  assign nz_s[0]  = 1'b0;
  assign max_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (issue_oh_s[r]),
      .dec     (rel_oh_s[r]),
      .clr     (Flush),
      .count   (cnt_s[r]),
      .nonzero (nz_s[r]),
      .at_max  (max_s[r])
    );
  end

  // Stall decision; saturation ignores a same-cycle release on purpose.
  always_comb begin
    hazard_s = 1'b0;
    if (Issue_valid) begin
      hazard_s = pending(Src1, cnt_s[Src1], Wb_valid, Wb_dst)
              || (Src2_valid && pending(Src2, cnt_s[Src2], Wb_valid, Wb_dst))
              || (Issue_wb_en && (Issue_dst != R0) && max_s[Issue_dst]);
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign issue_fire_s = Issue_valid && !hazard_s && Issue_wb_en && (Issue_dst != R0);

  // One-hot issue/release decode for the tracked registers.
  always_comb begin
    issue_oh_s = '0;
    rel_oh_s   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      issue_oh_s[r] = issue_fire_s && (Issue_dst == ADDR_W'(r));
      rel_oh_s[r]   = Wb_valid && (Wb_dst == ADDR_W'(r)) && nz_s[r];
    end
  end

  assign underflow_evt_s = Wb_valid && (Wb_dst != R0) && !nz_s[Wb_dst];

  // Sticky underflow flag, cleared only by reset or Flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_r <= 1'b0;
    end else if (Flush) begin
      underflow_r <= 1'b0;
    end else if (underflow_evt_s) begin
      underflow_r <= 1'b1;
    end else begin
      underflow_r <= underflow_r;
    end
  end

  assign Hazard_detected_signal = hazard_s;
  assign Busy                   = |nz_s[NUM_REGS-1:1];
  assign Wb_underflow           = underflow_r;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: a behavioural count model predicts
// each cycle's outputs, queued at drive time and compared at the falling edge.
module tb_wb_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Issue_valid, Issue_wb_en, Src2_valid, Wb_valid, Flush;
  logic [4:0] Issue_dst, Src1, Src2, Wb_dst;
  logic       Hazard_detected_signal, Busy, Wb_underflow;

  typedef struct packed {
    logic hz;
    logic busy;
    logic uf;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt [32];
  logic m_uf;
  int   total = 0;
  int   bad   = 0;

  wb_scoreboard dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .Issue_valid            (Issue_valid),
    .Issue_wb_en            (Issue_wb_en),
    .Issue_dst              (Issue_dst),
    .Src1                   (Src1),
    .Src2                   (Src2),
    .Src2_valid             (Src2_valid),
    .Wb_valid               (Wb_valid),
    .Wb_dst                 (Wb_dst),
    .Flush                  (Flush),
    .Hazard_detected_signal (Hazard_detected_signal),
    .Busy                   (Busy),
    .Wb_underflow           (Wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%b want=%b", tag, $time, obs, exp);
    end
  endtask

  function automatic logic m_pend(input logic [4:0] s);
    return (s != 5'd0) && (m_cnt[s] != 0)
        && !(Wb_valid && (Wb_dst == s) && (m_cnt[s] == 1));
  endfunction

  function automatic logic m_hazard();
    if (!Issue_valid) return 1'b0;
    return m_pend(Src1) || (Src2_valid && m_pend(Src2))
        || (Issue_wb_en && (Issue_dst != 5'd0) && (m_cnt[Issue_dst] == 3));
  endfunction

  function automatic logic m_busy();
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_uf = 1'b0;
  endtask

  // Drive one cycle, predict outputs, check at negedge, advance the model at posedge.
  task automatic step(input string tag, input logic iv, input logic wen,
                      input logic [4:0] dst, input logic [4:0] s1,
                      input logic [4:0] s2, input logic s2v, input logic wbv,
                      input logic [4:0] wd, input logic fl);
    exp_t e;
    logic hz, fire, rel;
    Issue_valid = iv; Issue_wb_en = wen; Issue_dst = dst;
    Src1 = s1; Src2 = s2; Src2_valid = s2v;
    Wb_valid = wbv; Wb_dst = wd; Flush = fl;
    hz = m_hazard();
    exp_q.push_back('{hz: hz, busy: m_busy(), uf: m_uf});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".hazard"}, Hazard_detected_signal, e.hz);
    chk({tag, ".busy"}, Busy, e.busy);
    chk({tag, ".underflow"}, Wb_underflow, e.uf);
    @(posedge clk);
    if (fl) begin
      m_clear();
    end else begin
      fire = iv && !hz && wen && (dst != 5'd0);
      rel  = wbv && (wd != 5'd0) && (m_cnt[wd] != 0);
      if (wbv && (wd != 5'd0) && (m_cnt[wd] == 0)) m_uf = 1'b1;
      if (rel)  m_cnt[wd]  = m_cnt[wd] - 1;
      if (fire) m_cnt[dst] = m_cnt[dst] + 1;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wb(input string tag, input logic [4:0] wd);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, wd, 1'b0);
  endtask

  task automatic issue(input string tag, input logic [4:0] dst);
    step(tag, 1'b1, 1'b1, dst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    m_clear();
    rst_n = 1'b0;
    Issue_valid = 1'b0; Issue_wb_en = 1'b0; Issue_dst = 5'd0;
    Src1 = 5'd0; Src2 = 5'd0; Src2_valid = 1'b0;
    Wb_valid = 1'b0; Wb_dst = 5'd0; Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hazard", Hazard_detected_signal, 1'b0);
    chk("rst.busy", Busy, 1'b0);
    chk("rst.underflow", Wb_underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean sources after reset
    step("clean", 1'b1, 1'b0, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);

    // RAW on r3, released by bypassed WB
    issue("iss_r3", 5'd3);
    step("raw_r3a", 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("raw_r3b", 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("byp_r3", 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    idle("after_r3");

    // Saturate r7, release one, retry
    repeat (3) issue("sat_r7", 5'd7);
    issue("sat_stall", 5'd7);
    step("sat_wbsame", 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    issue("sat_retry", 5'd7);
    issue("sat_full", 5'd7);
    repeat (3) wb("drain_r7", 5'd7);
    idle("drained_r7");

    // Simultaneous issue and release on r4
    issue("iss_r4", 5'd4);
    step("same_r4", 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    idle("still_r4");
    wb("wb_r4", 5'd4);
    idle("clear_r4");

    // Underflow then flush
    wb("uf_r9", 5'd9);
    idle("uf_sticky");
    issue("pre_flush", 5'd2);
    step("flush", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle("post_flush");

    // Src2 gating and register 0
    issue("iss_r2", 5'd2);
    step("src2_off", 1'b1, 1'b0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    step("src2_on", 1'b1, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    issue("iss_r0", 5'd0);
    step("src_r0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    wb("wb_r2", 5'd2);

    // Constrained random traffic on a few registers
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0));
    end

    // Reset asserted mid-stall
    step("pre_rst", 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    issue("iss_r5", 5'd5);
    step("stall_r5", 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    Issue_valid = 1'b1; Src1 = 5'd5; Issue_wb_en = 1'b0;
    Wb_valid = 1'b0; Flush = 1'b0;
    #1;
    chk("midrst.pre", Hazard_detected_signal, 1'b1);
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("midrst.hazard", Hazard_detected_signal, 1'b0);
    chk("midrst.busy", Busy, 1'b0);
    chk("midrst.underflow", Wb_underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Register-writeback scoreboard for the 5-stage pipeline. Tracks every in-flight instruction that will write a destination register, from issue in ID until retirement in WB. Raises a stall to ID whenever an instruction's source operand is still pending, or when its destination's tracking counter is saturated. It is the producer side of hazard detection: it records destinations as they enter the pipe and releases them at writeback.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; register 0 is never tracked
- ADDR_W, 5, register address width
- CNT_W, 2, per-register in-flight counter width (max 3 pending writes per register)
- WB_BYPASS, 1, when 1, a same-cycle final writeback releases the source (no stall)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Issue_valid  in  1  ID holds a valid instruction attempting to issue
- Issue_wb_en  in  1  issuing instruction writes a register
- Issue_dst  in  ADDR_W  destination of issuing instruction
- Src1  in  ADDR_W  first source register of ID instruction
- Src2  in  ADDR_W  second source register
- Src2_valid  in  1  Src2 is read (0 for immediate forms)
- Wb_valid  in  1  WB stage retires a register write this cycle
- Wb_dst  in  ADDR_W  register written by WB
- Flush  in  1  synchronous clear of all tracking (pipeline drained/restarted)
- Hazard_detected_signal  out  1  stall ID/IF, bubble into EXE
- Busy  out  1  any register pending
- Wb_underflow  out  1  sticky: writeback to a register with zero pending count

## Operation
- State: one CNT_W-bit counter per register 1..NUM_REGS-1; register 0 is hardwired to count 0.
- Issue fires when Issue_valid && !Hazard_detected_signal && Issue_wb_en && Issue_dst != 0.
- Release fires when Wb_valid && Wb_dst != 0 && cnt[Wb_dst] != 0.
- Counter update per register r:
  - +1 on issue to r.
  - −1 on release of r.
  - Issue and release to the same r in the same cycle: unchanged.
- Hazard_detected_signal = Issue_valid && (P(Src1) || (Src2_valid && P(Src2)) || (Issue_wb_en && Issue_dst != 0 && cnt[Issue_dst] == max)).
  - P(s) = s != 0 && cnt[s] != 0 && !(WB_BYPASS && Wb_valid && Wb_dst == s && cnt[s] == 1).
  - Saturation check ignores a same-cycle release: conservative stall.
- Wb_valid with Wb_dst == 0: ignored, no error.
- Wb_valid with Wb_dst != 0 and cnt == 0: no counter change; Wb_underflow sets and stays set until reset or Flush.
- Flush: all counters and Wb_underflow clear at next edge. Flush overrides any same-cycle issue or release.
- Busy = OR of all counters != 0 (registered state, not lookahead).

## Timing
- Reset (async assert, sync-to-clk deassert assumed upstream):
  - All counters 0.
  - Wb_underflow 0.
  - Busy 0.
  - Hazard_detected_signal 0 whenever Issue_valid is 0.
- Hazard_detected_signal is combinational from current counters and same-cycle inputs; zero-cycle latency to ID.
- Counter updates are visible to Hazard/Busy on the cycle after the issuing/retiring edge.
- Back-to-back dependent instructions: producer issues cycle N → consumer in ID at N+1 sees the pending count and stalls until the producer's WB cycle, which with WB_BYPASS=1 releases that same cycle.
- Reset asserted mid-operation: all in-flight tracking discarded immediately; no stall after reset.

## Structure
- Shared package cpu_pkg:
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - SB_CNT_W = 2
  - The register-0 constant
- Sub-module sb_counter: one saturating up/down counter with inc, dec, clr, and outputs nonzero/at_max. Instantiated with generate for registers 1..NUM_REGS-1.
- The top level holds the decode of Issue_dst/Wb_dst into one-hots, the hazard compare, and the Busy reduction.

## Test plan
- Reset release, Issue_valid=1, Src1=5, Src2=6, no prior issue → Hazard=0, Busy=0.
- Issue wb to r3 at cycle 0; cycle 1 ID Src1=3 → Hazard=1 until Wb_valid Wb_dst=3. With WB_BYPASS=1, Hazard=0 in that WB cycle; the counter reads 0 next cycle.
- Three issues to r7 with no WB (cnt=3), fourth Issue_dst=7 → Hazard=1. One WB r7 → issue accepted the following cycle, cnt returns to 3.
- Same cycle: issue to r4 and Wb_dst=4 with cnt[4]=1 → cnt[4] stays 1, Busy stays 1.
- Wb_valid Wb_dst=9 with cnt[9]=0 → Wb_underflow=1 next cycle, no counter change. Then Flush → Wb_underflow=0 and Busy=0 next cycle.
- Src2=2 pending with Src2_valid=0 → Hazard=0. Src1=0 and Issue_dst=0 with r0 "issued" → never tracked, Hazard=0. Assert rst_n low mid-stall → Hazard drops immediately.
